// File: rtl/ips_dbc_capture_ctrl_v1_1_if.sv
// Capture-sequencer bus: groups the control, trigger, memory-port and readout signals
// between the trigger unit / JTAG readout side (master) and the capture sequencer (slave).
//   arm, abort, post_cnt   : acquisition control
//   sample_en, trig_in     : storage qualifier and trigger condition
//   rd_en                  : readout word request
//   mem_wren, mem_wraddr   : capture memory write port
//   mem_rdaddr             : capture memory read port address
//   rd_valid, rd_last      : readout data qualifiers (aligned with registered memory q)
//   trig_addr, start_addr  : trigger sample and oldest sample addresses
//   state, done            : sequencer status
interface ips_dbc_capture_ctrl_v1_1_if #(
  parameter int unsigned DATA_DEPTH = 9
);
  logic                  arm;
  logic                  abort;
  logic [DATA_DEPTH-1:0] post_cnt;
  logic                  sample_en;
  logic                  trig_in;
  logic                  rd_en;
  logic                  mem_wren;
  logic [DATA_DEPTH-1:0] mem_wraddr;
  logic [DATA_DEPTH-1:0] mem_rdaddr;
  logic                  rd_valid;
  logic                  rd_last;
  logic [DATA_DEPTH-1:0] trig_addr;
  logic [DATA_DEPTH-1:0] start_addr;
  logic [2:0]            state;
  logic                  done;

  modport master (
    output arm, abort, post_cnt, sample_en, trig_in, rd_en,
    input  mem_wren, mem_wraddr, mem_rdaddr, rd_valid, rd_last,
    input  trig_addr, start_addr, state, done
  );

  modport slave (
    input  arm, abort, post_cnt, sample_en, trig_in, rd_en,
    output mem_wren, mem_wraddr, mem_rdaddr, rd_valid, rd_last,
    output trig_addr, start_addr, state, done
  );
endinterface

// File: rtl/ips_dbc_capture_ctrl_v1_1.sv
// Capture sequencer for the debug core's dual-port capture memory.
// Runs a circular pre-trigger / post-trigger acquisition, drives the memory write port,
// records the trigger sample address, then walks the read port in chronological order.
// Ports:
//   clk     : sample clock (also the memory write/read clock)
//   rst_n   : asynchronous active-low reset
//   ctrl_io : slave side of the capture bus (control inputs, memory ports, readout, status)
module ips_dbc_capture_ctrl_v1_1 #(
  parameter int unsigned DATA_DEPTH = 9
) (
  input logic                        clk,
  input logic                        rst_n,
  ips_dbc_capture_ctrl_v1_1_if.slave ctrl_io
);

  typedef logic [DATA_DEPTH-1:0] addr_t;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPre      = 3'd1,
    StWaitTrig = 3'd2,
    StPost     = 3'd3,
    StDone     = 3'd4
  } state_e;

  state_e state_q, state_d;
  addr_t  wr_ptr_q, wr_ptr_d;
  addr_t  pre_cnt_q, pre_cnt_d;
  addr_t  remaining_q, remaining_d;
  addr_t  post_q, post_d;
  addr_t  trig_addr_q, trig_addr_d;
  addr_t  start_addr_q, start_addr_d;
  addr_t  rd_idx_q, rd_idx_d;
  addr_t  rdaddr_q, rdaddr_d;

  // Two-stage readout pipeline: stage 1 tracks the address register, stage 2 the memory q.
  logic   rd_issue;
  logic   rd_issue_last;
  logic   rd_v1_q, rd_l1_q;
  logic   rd_valid_q, rd_last_q;

  logic   arm_ok;

  // arm only takes effect when no acquisition is in flight.
  assign arm_ok = ctrl_io.arm && ((state_q == StIdle) || (state_q == StDone));

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    pre_cnt_d     = pre_cnt_q;
    remaining_d   = remaining_q;
    post_d        = post_q;
    trig_addr_d   = trig_addr_q;
    start_addr_d  = start_addr_q;
    rd_idx_d      = rd_idx_q;
    rdaddr_d      = rdaddr_q;
    rd_issue      = 1'b0;
    rd_issue_last = 1'b0;

    if (ctrl_io.abort) begin
      state_d = StIdle;
    end else if (arm_ok) begin
      post_d      = ctrl_io.post_cnt;
      wr_ptr_d    = '0;
      pre_cnt_d   = '0;
      remaining_d = '0;
      rd_idx_d    = '0;
      // Pre-trigger depth N-1-P is zero exactly when P is all ones.
      state_d     = (&ctrl_io.post_cnt) ? StWaitTrig : StPre;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StIdle;
        end
        StPre: begin
          if (ctrl_io.sample_en) begin
            wr_ptr_d  = wr_ptr_q + addr_t'(1);
            pre_cnt_d = pre_cnt_q + addr_t'(1);
            // N-1-P in DATA_DEPTH bits is the bitwise complement of P.
            if (pre_cnt_d == ~post_q) begin
              state_d = StWaitTrig;
            end
          end
        end
        StWaitTrig: begin
          if (ctrl_io.sample_en) begin
            wr_ptr_d = wr_ptr_q + addr_t'(1);
            if (ctrl_io.trig_in) begin
              trig_addr_d = wr_ptr_q;
              remaining_d = post_q;
              if (post_q == '0) begin
                state_d      = StDone;
                start_addr_d = wr_ptr_d;
                rd_idx_d     = '0;
              end else begin
                state_d = StPost;
              end
            end
          end
        end
        StPost: begin
          if (ctrl_io.sample_en) begin
            wr_ptr_d    = wr_ptr_q + addr_t'(1);
            remaining_d = remaining_q - addr_t'(1);
            if (remaining_q == addr_t'(1)) begin
              state_d      = StDone;
              start_addr_d = wr_ptr_d;
              rd_idx_d     = '0;
            end
          end
        end
        StDone: begin
          if (ctrl_io.rd_en) begin
            rd_issue      = 1'b1;
            rd_issue_last = &rd_idx_q;
            rdaddr_d      = start_addr_q + rd_idx_q;
            rd_idx_d      = rd_idx_q + addr_t'(1);
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      pre_cnt_q    <= '0;
      remaining_q  <= '0;
      post_q       <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      rd_idx_q     <= '0;
      rdaddr_q     <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      pre_cnt_q    <= pre_cnt_d;
      remaining_q  <= remaining_d;
      post_q       <= post_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
      rd_idx_q     <= rd_idx_d;
      rdaddr_q     <= rdaddr_d;
    end
  end

  // abort flushes reads in flight so no stale word is flagged valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1_q    <= 1'b0;
      rd_l1_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else if (ctrl_io.abort) begin
      rd_v1_q    <= 1'b0;
      rd_l1_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      rd_v1_q    <= rd_issue;
      rd_l1_q    <= rd_issue_last;
      rd_valid_q <= rd_v1_q;
      rd_last_q  <= rd_l1_q && rd_v1_q;
    end
  end

  assign ctrl_io.mem_wren   = ctrl_io.sample_en &&
                              ((state_q == StPre) || (state_q == StWaitTrig) ||
                               (state_q == StPost));
  assign ctrl_io.mem_wraddr = wr_ptr_q;
  assign ctrl_io.mem_rdaddr = rdaddr_q;
  assign ctrl_io.rd_valid   = rd_valid_q;
  assign ctrl_io.rd_last    = rd_last_q;
  assign ctrl_io.trig_addr  = trig_addr_q;
  assign ctrl_io.start_addr = start_addr_q;
  assign ctrl_io.state      = state_q;
  assign ctrl_io.done       = (state_q == StDone);

endmodule

// File: tb/tb_ips_dbc_capture_ctrl_v1_1.sv
// Bench for ips_dbc_capture_ctrl_v1_1 with DATA_DEPTH = 4 (16-entry buffer).
// Stimulus pushes expected write addresses and readout words into queues; a monitor on the
// falling edge pops and compares whenever the DUT writes or presents a readout word.
module tb_ips_dbc_capture_ctrl_v1_1;
  localparam int unsigned DD = 4;
  localparam int unsigned NS = 16;

  typedef struct packed {
    int unsigned data;
    logic        last;
  } rd_exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  ips_dbc_capture_ctrl_v1_1_if #(.DATA_DEPTH(DD)) bus ();

  ips_dbc_capture_ctrl_v1_1 #(.DATA_DEPTH(DD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctrl_io (bus)
  );

  always #5 clk = ~clk;

  // Capture memory model: registered q, same clock for both ports.
  logic [7:0] mem [NS];
  logic [7:0] mem_q;
  logic [7:0] wdata;
  always @(posedge clk) begin
    if (bus.mem_wren) mem[bus.mem_wraddr] <= wdata;
    mem_q <= mem[bus.mem_rdaddr];
  end

  int unsigned wq[$];
  rd_exp_t     rq[$];
  int          checks   = 0;
  int          failures = 0;
  int          sid      = 0;

  function automatic void check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor
  always @(negedge clk) begin
    rd_exp_t e;
    if (bus.mem_wren) begin
      check("wr_pending", longint'(wq.size() != 0), 1);
      if (wq.size() != 0) check("wr_addr", bus.mem_wraddr, wq.pop_front());
    end
    if (bus.rd_valid) begin
      check("rd_pending", longint'(rq.size() != 0), 1);
      if (rq.size() != 0) begin
        e = rq.pop_front();
        check("rd_data", mem_q, e.data);
        check("rd_last", bus.rd_last, e.last);
      end
    end
    if (bus.rd_last) check("rd_last_qual", bus.rd_valid, 1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input int p);
    bus.post_cnt = DD'(p);
    bus.arm      = 1'b1;
    step();
    bus.arm      = 1'b0;
  endtask

  // n qualified samples at consecutive addresses from 'first'; optional trigger on the last.
  // With gaps, each is followed by an unqualified cycle carrying trig_in = 1.
  task automatic run_writes(input int n, input int first, input bit trig_last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      bus.sample_en = 1'b1;
      bus.trig_in   = trig_last && (i == n - 1);
      wdata         = 8'(sid);
      sid++;
      wq.push_back((first + i) % NS);
      step();
      if (gaps) begin
        bus.sample_en = 1'b0;
        bus.trig_in   = 1'b1;
        step();
      end
    end
    bus.sample_en = 1'b0;
    bus.trig_in   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, bus.state, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_wren"}, bus.mem_wren, 0);
    check({tag, "_wraddr"}, bus.mem_wraddr, 0);
    check({tag, "_rdaddr"}, bus.mem_rdaddr, 0);
    check({tag, "_rd_valid"}, bus.rd_valid, 0);
    check({tag, "_rd_last"}, bus.rd_last, 0);
    check({tag, "_trig_addr"}, bus.trig_addr, 0);
    check({tag, "_start_addr"}, bus.start_addr, 0);
  endtask

  initial begin
    bus.arm = 1'b0; bus.abort = 1'b0; bus.post_cnt = '0;
    bus.sample_en = 1'b0; bus.trig_in = 1'b0; bus.rd_en = 1'b0;
    wdata = '0;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("por");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    bus.sample_en = 1'b1; bus.trig_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_no_arm_state", bus.state, 0);
    end
    bus.sample_en = 1'b0; bus.trig_in = 1'b0;

    // P = 4, trigger in PRE ignored, trigger at 13.
    do_arm(4);
    check("s1_arm_state", bus.state, 1);
    run_writes(2, 0, 0, 0);
    run_writes(1, 2, 1, 0);
    run_writes(8, 3, 0, 0);
    check("s1_wait_state", bus.state, 2);
    run_writes(2, 11, 0, 0);
    run_writes(1, 13, 1, 0);
    check("s1_post_state", bus.state, 3);
    check("s1_trig_addr", bus.trig_addr, 13);
    run_writes(4, 14, 0, 0);
    check("s1_done", bus.done, 1);
    check("s1_done_state", bus.state, 4);
    check("s1_start_addr", bus.start_addr, 2);
    bus.sample_en = 1'b1;
    step(); step();
    bus.sample_en = 1'b0;

    // Readout: sample ids 0..17 landed at addr id%16, so chronological data is 2..17.
    for (int i = 0; i < 16; i++) rq.push_back('{data: 2 + i, last: (i == 15)});
    bus.rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      check("rdaddr_seq", bus.mem_rdaddr, (2 + i) % NS);
      check("rd_valid_latency", bus.rd_valid, (i >= 1) ? 1 : 0);
    end
    bus.rd_en = 1'b0;
    step(); step(); step();
    check("rd_queue_drained", rq.size(), 0);

    // P = 15 from DONE, with a simultaneous rd_en that must be dropped.
    bus.rd_en = 1'b1;
    do_arm(15);
    bus.rd_en = 1'b0;
    bus.post_cnt = 4'd3;
    check("s2_arm_state", bus.state, 2);
    check("s2_rdaddr_held", bus.mem_rdaddr, 1);
    run_writes(1, 0, 1, 0);
    check("s2_post_state", bus.state, 3);
    check("s2_trig_addr", bus.trig_addr, 0);
    run_writes(15, 1, 0, 0);
    check("s2_done", bus.done, 1);
    check("s2_start_addr", bus.start_addr, 0);
    step(); step();

    // P = 0.
    do_arm(0);
    check("s3_arm_state", bus.state, 1);
    run_writes(15, 0, 0, 0);
    check("s3_wait_state", bus.state, 2);
    run_writes(1, 15, 1, 0);
    check("s3_done_state", bus.state, 4);
    check("s3_trig_addr", bus.trig_addr, 15);
    check("s3_start_addr", bus.start_addr, 0);

    // P = 4 with qualifier gaps.
    do_arm(4);
    run_writes(11, 0, 0, 1);
    check("s4_wait_state", bus.state, 2);
    run_writes(2, 11, 0, 1);
    check("s4_still_wait", bus.state, 2);
    run_writes(1, 13, 1, 1);
    check("s4_trig_addr", bus.trig_addr, 13);
    run_writes(3, 14, 0, 1);
    check("s4_post_state", bus.state, 3);
    run_writes(1, 1, 0, 1);
    check("s4_done", bus.done, 1);
    check("s4_start_addr", bus.start_addr, 2);

    // Abort during POST; the abort cycle itself still qualifies a write.
    do_arm(4);
    run_writes(11, 0, 0, 0);
    run_writes(1, 11, 1, 0);
    check("s5_post_state", bus.state, 3);
    run_writes(2, 12, 0, 0);
    bus.abort = 1'b1; bus.sample_en = 1'b1; wdata = 8'hAA;
    wq.push_back(14);
    step();
    bus.abort = 1'b0;
    check("s5_abort_state", bus.state, 0);
    check("s5_abort_done", bus.done, 0);
    step(); step();
    bus.sample_en = 1'b0;
    check("s5_trig_addr_held", bus.trig_addr, 11);
    check("s5_start_addr_held", bus.start_addr, 2);
    bus.abort = 1'b1;
    do_arm(4);
    bus.abort = 1'b0;
    check("s5_arm_abort_state", bus.state, 0);
    do_arm(15);
    check("s5_rearm_state", bus.state, 2);
    check("s5_rearm_wraddr", bus.mem_wraddr, 0);

    // Asynchronous reset mid-POST.
    run_writes(1, 0, 1, 0);
    run_writes(3, 1, 0, 0);
    check("s6_post_state", bus.state, 3);
    check("s6_pre_rst_wraddr", bus.mem_wraddr, 4);
    bus.sample_en = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.trig_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("s6_post_rst_state", bus.state, 0);
    end
    bus.sample_en = 1'b0; bus.trig_in = 1'b0;
    step();

    check("wr_queue_empty", wq.size(), 0);
    check("rd_queue_empty", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
